dmem_arbiter: RTL and testbench

Sequential arbiter and access controller that shares the single-port data memory between two requesters: requester 0 is the CPU load/store stage and requester 1 is the debug/loader port. Requests use a req/gnt/done handshake, round-robin priority and a registered 3-state access sequence. The block drives the memory's `mem_read`, `memwrite`, `address` and `writedata` inputs and captures `readdata`. It is the only master of the data memory.

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_rr_pick.sv | 19 +
 rtl/dmem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-input round-robin select with one-hot winner
module dmem_rr_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      if (req == 2'b11) begin
         win = (rr == REQ_DBG) ? 2'b10 : 2'b01;
      end else begin
         win = req;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data memory between CPU and debug port
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r1_req,
   input  logic              r0_we,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r0_gnt,
   output logic              r1_gnt,
   output logic              r0_done,
   output logic              r1_done,
   output logic              r0_err,
   output logic              r1_err,
   output logic [DATA_W-1:0] r0_rdata,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_read,
   output logic              memwrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);

   localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(DEPTH);

   state_t              r_state;
   state_t              w_next;
   logic                r_rr;
   logic                r_id;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_err;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;
   logic                r_mem_read;
   logic                r_memwrite;
   logic [ADDR_W-1:0]   r_mem_address;
   logic [DATA_W-1:0]   r_mem_writedata;

   logic [1:0]          w_win;
   logic [1:0]          w_gnt;
   logic [1:0]          w_done;
   logic [1:0]          w_err;
   logic                w_any;
   logic                w_sel;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_in_range;
   logic                w_lat_in_range;
   logic [DATA_W-1:0]   w_cap;

   dmem_rr_pick u_pick (
      .req ({r1_req, r0_req}),
      .rr  (r_rr),
      .win (w_win)
   );

   assign w_any          = r0_req | r1_req;
   assign w_sel          = w_win[REQ_DBG];
   assign w_we           = (w_sel == REQ_DBG) ? r1_we    : r0_we;
   assign w_addr         = (w_sel == REQ_DBG) ? r1_addr  : r0_addr;
   assign w_wdata        = (w_sel == REQ_DBG) ? r1_wdata : r0_wdata;
   assign w_in_range     = (w_addr < L_DEPTH);
   assign w_lat_in_range = (r_addr < L_DEPTH);
   assign w_cap          = (w_lat_in_range && !r_we) ? mem_readdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_gnt  = 2'b00;
      w_done = 2'b00;
      w_err  = 2'b00;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_gnt  = w_win;
               w_next = ACCESS;
            end
         end
         ACCESS: w_next = DONE;
         DONE: begin
            w_done[r_id] = 1'b1;
            w_err[r_id]  = r_err;
            w_next       = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Memory enables are registered on the grant edge so they cover exactly the ACCESS cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr            <= REQ_CPU;
         r_id            <= REQ_CPU;
         r_we            <= 1'b0;
         r_addr          <= '0;
         r_err           <= 1'b0;
         r_rdata0        <= '0;
         r_rdata1        <= '0;
         r_mem_read      <= 1'b0;
         r_memwrite      <= 1'b0;
         r_mem_address   <= '0;
         r_mem_writedata <= '0;
      end else begin
         r_mem_read      <= 1'b0;
         r_memwrite      <= 1'b0;
         r_mem_address   <= '0;
         r_mem_writedata <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_id   <= w_sel;
                  r_we   <= w_we;
                  r_addr <= w_addr;
                  r_rr   <= ~w_sel;
                  if (w_in_range) begin
                     r_mem_read      <= ~w_we;
                     r_memwrite      <= w_we;
                     r_mem_address   <= w_addr;
                     r_mem_writedata <= w_wdata;
                  end
               end
            end
            ACCESS: begin
               r_err <= ~w_lat_in_range;
               if (r_id == REQ_DBG) begin
                  r_rdata1 <= w_cap;
               end else begin
                  r_rdata0 <= w_cap;
               end
            end
            default: ;
         endcase
      end
   end

   assign r0_gnt        = w_gnt[REQ_CPU];
   assign r1_gnt        = w_gnt[REQ_DBG];
   assign r0_done       = w_done[REQ_CPU];
   assign r1_done       = w_done[REQ_DBG];
   assign r0_err        = w_err[REQ_CPU];
   assign r1_err        = w_err[REQ_DBG];
   assign r0_rdata      = r_rdata0;
   assign r1_rdata      = r_rdata1;
   assign mem_read      = r_mem_read;
   assign memwrite      = r_memwrite;
   assign mem_address   = r_mem_address;
   assign mem_writedata = r_mem_writedata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with behavioural model
module tb_dmem_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          r0_req = 1'b0, r1_req = 1'b0;
   logic          r0_we = 1'b0, r1_we = 1'b0;
   logic [AW-1:0] r0_addr = '0, r1_addr = '0;
   logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
   logic          r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          mem_read, memwrite;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_writedata, mem_readdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
      .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
      .r0_err(r0_err), .r1_err(r1_err), .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
      .mem_read(mem_read), .memwrite(memwrite), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
   );

   // Memory the DUT drives: word i holds i*10.
   logic [DW-1:0] bmem [0:DEPTH-1];
   assign mem_readdata = (mem_address < DEPTH) ? bmem[mem_address[6:0]] : '0;
   always @(posedge clk) if (memwrite && mem_address < DEPTH) bmem[mem_address[6:0]] <= mem_writedata;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an access is a transaction that occupies 3 cycles from its grant.
   int            m_phase;
   bit            m_rr, m_id, m_we;
   logic [31:0]   m_addr, m_wdata;
   logic [31:0]   m_rdata [2];
   logic [31:0]   m_mem [DEPTH];
   bit            w, inr;
   logic [1:0]    e_g, e_d, e_e;
   logic          e_rd, e_wr;
   logic [31:0]   e_a, e_wd;

   task automatic model_reset();
      m_phase = 0; m_rr = 1'b0; m_id = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
   endtask

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         e_g = 2'b00; e_d = 2'b00; e_e = 2'b00; e_rd = 1'b0; e_wr = 1'b0; e_a = '0; e_wd = '0;
         inr = (m_addr < DEPTH);
         w = 1'b0;
         if (m_phase == 0) begin
            if (r0_req || r1_req) begin
               w = (r0_req && r1_req) ? m_rr : r1_req;
               e_g[w] = 1'b1;
            end
         end else if (m_phase == 1) begin
            e_rd = inr && !m_we;
            e_wr = inr && m_we;
            e_a  = inr ? m_addr : '0;
            e_wd = inr ? m_wdata : '0;
         end else begin
            e_d[m_id] = 1'b1;
            e_e[m_id] = !inr;
         end
         chk("gnt", {r1_gnt, r0_gnt}, e_g);
         chk("done", {r1_done, r0_done}, e_d);
         chk("err", {r1_err, r0_err}, e_e);
         chk("mem_read", mem_read, e_rd);
         chk("memwrite", memwrite, e_wr);
         chk("mem_address", mem_address, e_a);
         chk("mem_writedata", mem_writedata, e_wd);
         chk("r0_rdata", r0_rdata, m_rdata[0]);
         chk("r1_rdata", r1_rdata, m_rdata[1]);
         if (m_phase == 0) begin
            if (r0_req || r1_req) begin
               m_id    = w;
               m_we    = w ? r1_we : r0_we;
               m_addr  = w ? r1_addr : r0_addr;
               m_wdata = w ? r1_wdata : r0_wdata;
               m_rr    = !w;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (inr && m_we) m_mem[m_addr[6:0]] = m_wdata;
            m_rdata[m_id] = (inr && !m_we) ? m_mem[m_addr[6:0]] : '0;
            m_phase = 2;
         end else begin
            m_phase = 0;
         end
      end
   end

   logic s_g0 = 1'b0, s_g1 = 1'b0;
   always @(negedge clk) begin
      s_g0 <= r0_gnt;
      s_g1 <= r1_gnt;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst_n  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
   endtask

   logic acc_rd, acc_wr, d_done, d_err;
   logic [31:0] acc_a, d_rdata;

   // Single isolated access from an idle arbiter; returns at the done-cycle negedge.
   task automatic run_req(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wd);
      if (id) begin r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
      else    begin r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
      @(negedge clk);
      chk("run_gnt", id ? r1_gnt : r0_gnt, 1'b1);
      tick();
      r0_req = 1'b0; r1_req = 1'b0;
      @(negedge clk);
      acc_rd = mem_read; acc_wr = memwrite; acc_a = mem_address;
      tick();
      @(negedge clk);
      d_done  = id ? r1_done : r0_done;
      d_err   = id ? r1_err : r0_err;
      d_rdata = id ? r1_rdata : r0_rdata;
      chk("run_done_no_enable", {mem_read, memwrite}, 2'b00);
   endtask

   task automatic new_req(input bit id);
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 7)      a = $urandom_range(0, 15);
      else if (r < 9) a = $urandom_range(120, 135);
      else            a = $urandom;
      if (id) begin r1_req = 1'b1; r1_we = $urandom_range(0, 1); r1_addr = a; r1_wdata = $urandom; end
      else    begin r0_req = 1'b1; r0_we = $urandom_range(0, 1); r0_addr = a; r0_wdata = $urandom; end
   endtask

   int gq[$];
   int dcyc[$], did[$], drd[$];
   int wcnt;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         bmem[i]  = 32'(i * 10);
         m_mem[i] = 32'(i * 10);
      end
      model_reset();
      #12;
      chk("rst_gnt_done_err", {r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err}, 6'd0);
      chk("rst_enables", {mem_read, memwrite}, 2'b00);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_wdata", mem_writedata, 32'd0);
      chk("rst_rdata", r0_rdata | r1_rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;

      // 1: single read
      run_req(0, 0, 5, 0);
      chk("t1_mem_read", acc_rd, 1'b1);
      chk("t1_mem_addr", acc_a, 32'd5);
      chk("t1_done", d_done, 1'b1);
      chk("t1_rdata", d_rdata, 32'd50);
      chk("t1_err", d_err, 1'b0);
      tick();

      // 2: write then read back
      run_req(1, 1, 12, 32'hDEADBEEF);
      chk("t2_memwrite", {acc_wr, acc_rd}, 2'b10);
      chk("t2_addr", acc_a, 32'd12);
      chk("t2_wr_rdata", d_rdata, 32'd0);
      tick();
      run_req(1, 0, 12, 0);
      chk("t2_readback", d_rdata, 32'hDEADBEEF);
      tick();

      // 3: contention from reset
      do_reset();
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 1;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 2;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (r0_gnt) gq.push_back(0);
         if (r1_gnt) gq.push_back(1);
         if (r0_done) begin dcyc.push_back(c); did.push_back(0); drd.push_back(int'(r0_rdata)); end
         if (r1_done) begin dcyc.push_back(c); did.push_back(1); drd.push_back(int'(r1_rdata)); end
         tick();
         if (c == 10) begin r0_req = 1'b0; r1_req = 1'b0; end
      end
      chk("t3_ngrants", gq.size(), 4);
      chk("t3_ndones", dcyc.size(), 4);
      if (gq.size() == 4 && dcyc.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            chk("t3_gnt_order", gq[k], k % 2);
            chk("t3_done_id", did[k], k % 2);
            chk("t3_done_cycle", dcyc[k], 2 + 3 * k);
            chk("t3_rdata", drd[k], (k % 2) ? 20 : 10);
         end
      end

      // 4: out of range
      run_req(0, 0, 128, 0);
      chk("t4_no_enable", {acc_rd, acc_wr}, 2'b00);
      chk("t4_done", d_done, 1'b1);
      chk("t4_err", d_err, 1'b1);
      chk("t4_rdata", d_rdata, 32'd0);
      tick();

      // 6: back-to-back re-raise in the done cycle
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 3;
      @(negedge clk); chk("t6_gnt1", r1_gnt, 1'b1);
      tick(); r1_req = 1'b0;
      tick(); r1_req = 1'b1; r1_addr = 4;
      @(negedge clk);
      chk("t6_done1", r1_done, 1'b1);
      chk("t6_rdata1", r1_rdata, 32'd30);
      tick();
      @(negedge clk); chk("t6_gnt2", r1_gnt, 1'b1);
      tick(); r1_req = 1'b0;
      tick();
      @(negedge clk); chk("t6_rdata2", r1_rdata, 32'd40);
      tick();

      // 5: reset during the ACCESS cycle of a write
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 7; r0_wdata = 32'h1234;
      @(negedge clk); chk("t5_gnt", r0_gnt, 1'b1);
      tick(); r0_req = 1'b0;
      #2;
      chk("t5_mw_before", memwrite, 1'b1);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t5_mw_async", memwrite, 1'b0);
      chk("t5_addr", mem_address, 32'd0);
      chk("t5_wdata", mem_writedata, 32'd0);
      chk("t5_r1_rdata", r1_rdata, 32'd0);
      @(negedge clk);
      chk("t5_no_done", {r0_done, r1_done}, 2'b00);
      tick();
      rst_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 7;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8;
      @(negedge clk);
      chk("t5_rr_reset", {r1_gnt, r0_gnt}, 2'b01);
      tick(); r0_req = 1'b0;
      tick();
      @(negedge clk); chk("t5_write_dropped", r0_rdata, 32'd70);
      tick();
      @(negedge clk); chk("t5_loser_gnt", r1_gnt, 1'b1);
      tick(); r1_req = 1'b0;
      tick();
      @(negedge clk); chk("t5_r1_rdata80", r1_rdata, 32'd80);
      tick();

      // randomized traffic against the model
      repeat (3000) begin
         tick();
         if (r0_req) begin
            if (s_g0) begin
               if ($urandom_range(0, 2) == 0) new_req(0); else r0_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) new_req(0);
         if (r1_req) begin
            if (s_g1) begin
               if ($urandom_range(0, 2) == 0) new_req(1); else r1_req = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) new_req(1);
      end
      repeat (20) begin
         tick();
         if (r0_req && s_g0) r0_req = 1'b0;
         if (r1_req && s_g1) r1_req = 1'b0;
      end
      chk("drain_idle", {r0_req, r1_req}, 2'b00);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
